ffe_lms_update: RTL and testbench

FFE_LMS_UPDATE -- requirements
Module: ffe_lms_update

---
 rtl/ffe_lms_update.sv | 170 +++++++++++++++++
 tb/tb_ffe_lms_update.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ffe_lms_update.sv
// LMS coefficient adaptation for a 7-tap FFE: per-tap S(20,18) accumulators
// updated by -mu*e*x, with a warm-up/adapt/freeze control FSM.
module ffe_lms_update #(
  parameter int IN_BW   = 11,
  parameter int ERR_BW  = 9,
  parameter int COEF_BW = 9,
  parameter int N_COEF  = 7,
  parameter int ERR_DLY = 2,
  parameter int CENTER  = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic signed [IN_BW-1:0]     i_data,
  input  logic signed [ERR_BW-1:0]    i_err,
  input  logic                        i_err_valid,
  input  logic                        i_adapt_en,
  input  logic                        i_load,
  input  logic [3:0]                  i_mu_shift,
  output logic [COEF_BW*N_COEF-1:0]   o_coefs,
  output logic [1:0]                  o_state,
  output logic                        o_sat
);

  localparam int ACC_BW   = 20;
  localparam int ACC_FRAC = 18;
  localparam int DL_LEN   = N_COEF + ERR_DLY;
  localparam int WARM_LEN = N_COEF + ERR_DLY;
  localparam int CNT_BW   = $clog2(WARM_LEN + 1);
  localparam int PROD_BW  = IN_BW + ERR_BW;
  localparam int TERM_BW  = PROD_BW + 4;
  localparam int SUM_BW   = ((TERM_BW > ACC_BW) ? TERM_BW : ACC_BW) + 1;

  localparam logic [ACC_BW-1:0] ACC_ONE = ACC_BW'(1) << ACC_FRAC;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_ADAPT  = 2'd2;
  localparam logic [1:0] ST_FREEZE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic              upd;
  logic [N_COEF-1:0] clamp;

  // xd[0] is the live input; xd[j] is the sample j enabled cycles old
  logic signed [IN_BW-1:0] xd_q [1:DL_LEN-1];
  logic signed [IN_BW-1:0] xd   [0:DL_LEN-1];

  always_comb begin
    xd[0] = i_data;
    for (int j = 1; j < DL_LEN; j++) begin
      xd[j] = xd_q[j];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int j = 1; j < DL_LEN; j++) begin
        xd_q[j] <= '0;
      end
    end else if (i_en) begin
      xd_q[1] <= i_data;
      for (int j = 2; j < DL_LEN; j++) begin
        xd_q[j] <= xd_q[j-1];
      end
    end
  end

  assign upd = (state_q == ST_ADAPT) && i_en && i_err_valid;

  for (genvar gi = 0; gi < N_COEF; gi++) begin : g_tap
    localparam logic [ACC_BW-1:0] ACC_INIT = (gi == CENTER) ? ACC_ONE : '0;

    logic signed [PROD_BW-1:0] err_ext, x_ext, prod;
    logic signed [TERM_BW-1:0] term_sh, term;
    logic signed [SUM_BW-1:0]  sum;
    logic                      ovf;
    logic [ACC_BW-1:0]         acc_q, acc_d;
    logic [COEF_BW-1:0]        coef_q;

    // e*x carries 14 fraction bits; <<4 aligns it to the accumulator's 18
    assign err_ext = {{IN_BW{i_err[ERR_BW-1]}}, i_err};
    assign x_ext   = {{ERR_BW{xd[gi+ERR_DLY][IN_BW-1]}}, xd[gi+ERR_DLY]};
    assign prod    = err_ext * x_ext;
    assign term_sh = {prod, 4'b0000};
    assign term    = term_sh >>> i_mu_shift;
    assign sum     = {{(SUM_BW-ACC_BW){acc_q[ACC_BW-1]}}, acc_q}
                   - {{(SUM_BW-TERM_BW){term[TERM_BW-1]}}, term};
    assign ovf     = !((&sum[SUM_BW-1:ACC_BW-1]) || !(|sum[SUM_BW-1:ACC_BW-1]));

    always_comb begin
      acc_d = sum[ACC_BW-1:0];
      if (ovf) begin
        acc_d = sum[SUM_BW-1] ? {1'b1, {(ACC_BW-1){1'b0}}} : {1'b0, {(ACC_BW-1){1'b1}}};
      end
    end

    assign clamp[gi] = ovf;

    // The coefficient register is forced alongside the accumulator on
    // reset/load so the initial taps appear without an extra cycle.
    always_ff @(posedge i_clk) begin
      if (i_rst || i_load) begin
        acc_q  <= ACC_INIT;
        coef_q <= ACC_INIT[ACC_BW-1 -: COEF_BW];
      end else begin
        if (upd) begin
          acc_q <= acc_d;
        end
        coef_q <= acc_q[ACC_BW-1 -: COEF_BW];
      end
    end

    assign o_coefs[COEF_BW*gi +: COEF_BW] = coef_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q | (upd & (|clamp));
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_adapt_en && i_en) state_d = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (!i_adapt_en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (i_en) begin
          if (cnt_q == CNT_BW'(WARM_LEN - 1)) begin
            state_d = ST_ADAPT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ADAPT: begin
        if (!i_adapt_en) state_d = ST_FREEZE;
      end
      default: begin
        if (i_adapt_en) state_d = ST_ADAPT;
      end
    endcase
    if (i_load) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign o_state = state_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_ffe_lms_update.sv
// Self-checking bench for ffe_lms_update: table of single-update vectors plus
// hand sequences for FSM timing, tap alignment, freeze, saturation and load.
module tb_ffe_lms_update;
  localparam int IN_BW   = 11;
  localparam int ERR_BW  = 9;
  localparam int COEF_BW = 9;
  localparam int N_COEF  = 7;
  localparam int CW      = COEF_BW * N_COEF;

  logic                     i_clk = 1'b0;
  logic                     i_rst, i_en, i_err_valid, i_adapt_en, i_load;
  logic signed [IN_BW-1:0]  i_data;
  logic signed [ERR_BW-1:0] i_err;
  logic [3:0]               i_mu_shift;
  logic [CW-1:0]            o_coefs;
  logic [1:0]               o_state;
  logic                     o_sat;

  ffe_lms_update dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_data(i_data), .i_err(i_err),
    .i_err_valid(i_err_valid), .i_adapt_en(i_adapt_en), .i_load(i_load),
    .i_mu_shift(i_mu_shift), .o_coefs(o_coefs), .o_state(o_state), .o_sat(o_sat)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { string name; int kind; logic [CW-1:0] val; } exp_t;
  typedef struct { int data; int err; int mu; logic [8:0] c_exp; logic [8:0] o_exp; logic s_exp; } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [CW-1:0] init_c, exp_c;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [CW-1:0] mk_coefs(logic [8:0] c, logic [8:0] o);
    logic [CW-1:0] v;
    for (int k = 0; k < N_COEF; k++) v[COEF_BW*k +: COEF_BW] = (k == 3) ? c : o;
    return v;
  endfunction

  task automatic exp_coefs(string n, logic [CW-1:0] v);
    sb.push_back('{n, 0, v});
  endtask
  task automatic exp_state(string n, logic [1:0] s);
    sb.push_back('{n, 1, CW'(s)});
  endtask
  task automatic exp_sat(string n, logic s);
    sb.push_back('{n, 2, CW'(s)});
  endtask

  task automatic check_out();
    exp_t e;
    logic [CW-1:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = o_coefs;
        1:       act = CW'(o_state);
        default: act = CW'(o_sat);
      endcase
      n_tests++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
      end else begin
        $display("ok   %s: %h", e.name, act);
      end
    end
  endtask

  task automatic do_load();
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
  endtask

  initial begin
    vecs[0] = '{128,   64,  0, 9'h040, 9'h1C0, 1'b0};
    vecs[1] = '{128,   64,  2, 9'h070, 9'h1F0, 1'b0};
    vecs[2] = '{-128,  64,  1, 9'h0A0, 9'h020, 1'b0};
    vecs[3] = '{5,     3,   4, 9'h07F, 9'h1FF, 1'b0};
    vecs[4] = '{1023,  255, 15, 9'h07F, 9'h1FF, 1'b0};
    vecs[5] = '{1023,  255, 0, 9'h100, 9'h100, 1'b1};
    vecs[6] = '{-1024, 255, 0, 9'h0FF, 9'h0FF, 1'b1};
    init_c  = mk_coefs(9'h080, 9'h000);

    i_rst = 1'b1; i_en = 1'b0; i_err_valid = 1'b0; i_adapt_en = 1'b0; i_load = 1'b0;
    i_data = '0; i_err = '0; i_mu_shift = '0;
    tick(); tick();
    i_rst = 1'b0;
    exp_coefs("rst_coefs", init_c); exp_state("rst_state", 2'd0); exp_sat("rst_sat", 1'b0);
    check_out();

    // warm-up length, then with one disabled cycle inside
    i_adapt_en = 1'b1; i_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_state("warm_state", (i <= 9) ? 2'd1 : 2'd2);
      check_out();
    end
    do_load();
    exp_state("load_idle", 2'd0); check_out();
    for (int i = 1; i <= 11; i++) begin
      i_en = (i == 4) ? 1'b0 : 1'b1;
      tick();
      exp_state("warm_pause", (i <= 10) ? 2'd1 : 2'd2);
      check_out();
    end
    i_en = 1'b1;

    // abort warm-up, counter must restart from zero
    do_load();
    tick(); tick(); tick();
    i_adapt_en = 1'b0;
    tick();
    exp_state("warm_abort", 2'd0); check_out();
    i_adapt_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_state("warm_restart", (i <= 9) ? 2'd1 : 2'd2);
      check_out();
    end

    // impulse alignment: only the tap seeing xd[k+2] moves
    do_load();
    i_data = '0;
    repeat (10) tick();
    exp_state("imp_adapt", 2'd2); check_out();
    i_data = 11'sd128; tick();
    i_data = '0; tick(); tick(); tick();
    i_err = 9'sd64; i_mu_shift = 4'd0; i_err_valid = 1'b1;
    tick();
    i_err_valid = 1'b0;
    tick();
    exp_c = init_c; exp_c[COEF_BW*2 +: COEF_BW] = 9'h1C0;
    exp_coefs("imp_tap2", exp_c); check_out();

    // freeze holds coefficients, resume adapts again
    i_data = 11'sd128;
    repeat (9) tick();
    i_adapt_en = 1'b0; i_err = '0; i_err_valid = 1'b1;
    tick();
    exp_state("frz_state", 2'd3); check_out();
    i_err = 9'sd64;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_state("frz_hold_st", 2'd3); exp_coefs("frz_hold_c", exp_c); check_out();
    end
    i_adapt_en = 1'b1; i_err_valid = 1'b0;
    tick();
    exp_state("frz_resume", 2'd2); check_out();
    i_err_valid = 1'b1;
    tick();
    i_err_valid = 1'b0;
    tick();
    exp_c = mk_coefs(9'h040, 9'h1C0); exp_c[COEF_BW*2 +: COEF_BW] = 9'h180;
    exp_coefs("frz_upd", exp_c); check_out();

    // negative saturation, sticky flag, load clears everything mid-ADAPT
    do_load();
    i_data = -11'sd1023 - 11'sd1;
    repeat (10) tick();
    i_err = -9'sd256; i_err_valid = 1'b1;
    repeat (3) tick();
    i_err_valid = 1'b0;
    tick();
    exp_coefs("sat_coefs", mk_coefs(9'h100, 9'h100)); exp_sat("sat_flag", 1'b1); check_out();
    i_adapt_en = 1'b0;
    repeat (3) tick();
    exp_sat("sat_sticky", 1'b1); exp_state("sat_frz", 2'd3); check_out();
    i_adapt_en = 1'b1;
    tick();
    exp_state("sat_adapt", 2'd2); check_out();
    i_err_valid = 1'b1; i_load = 1'b1;
    tick();
    i_load = 1'b0; i_err_valid = 1'b0;
    exp_state("ld_state", 2'd0); exp_coefs("ld_coefs", init_c); exp_sat("ld_sat", 1'b0);
    check_out();

    // table of single updates from initial coefficients
    for (int v = 0; v < 7; v++) begin
      do_load();
      exp_state("vec_idle", 2'd0); check_out();
      i_data = IN_BW'(vecs[v].data); i_adapt_en = 1'b1; i_en = 1'b1; i_err_valid = 1'b0;
      repeat (10) tick();
      exp_state("vec_adapt", 2'd2); check_out();
      i_err = ERR_BW'(vecs[v].err); i_mu_shift = 4'(vecs[v].mu); i_err_valid = 1'b1;
      tick();
      i_err_valid = 1'b0;
      exp_coefs("vec_latency", init_c); check_out();
      tick();
      exp_coefs($sformatf("vec%0d_coefs", v), mk_coefs(vecs[v].c_exp, vecs[v].o_exp));
      exp_sat($sformatf("vec%0d_sat", v), vecs[v].s_exp);
      check_out();
    end

    // reset mid-ADAPT with a valid error pending
    i_err = -9'sd256; i_err_valid = 1'b1; i_rst = 1'b1;
    tick();
    i_rst = 1'b0; i_err_valid = 1'b0; i_adapt_en = 1'b0;
    exp_coefs("rst2_coefs", init_c); exp_state("rst2_state", 2'd0); exp_sat("rst2_sat", 1'b0);
    check_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
